// File: rtl/rj32_bus_pkg.sv
// Shared definitions for the rj32 data-memory bus: FSM encoding, I/O page map,
// address decode and the I/O register access payload.
package rj32_bus_pkg;

  localparam int unsigned ADR_W           = 16;
  localparam int unsigned DAT_W           = 16;
  localparam int unsigned SRAM_ADR_W      = 18;
  localparam int unsigned WAIT_W          = 3;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned LED_W           = 8;
  localparam int unsigned DEF_WAIT_STATES = 1;

  localparam logic [ADR_W-1:0] IO_BASE  = 16'hFF00;
  localparam logic [ADR_W-1:0] SRAM_TOP = 16'hEFFF;

  localparam logic [1:0] IO_CNT_LO = 2'd0;
  localparam logic [1:0] IO_CNT_HI = 2'd1;
  localparam logic [1:0] IO_LEDS   = 2'd2;
  localparam logic [1:0] IO_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } dm_state_e;

  typedef enum logic [1:0] {
    REGION_SRAM     = 2'd0,
    REGION_IO       = 2'd1,
    REGION_UNMAPPED = 2'd2
  } region_e;

  typedef struct packed {
    logic             wr;
    logic [1:0]       off;
    logic [LED_W-1:0] wdat;
  } io_req_t;

  // The I/O page is the four words IO_BASE..IO_BASE+3; the rest of 0xF000+ is unmapped.
  function automatic region_e dm_decode(input logic [ADR_W-1:0] adr);
    region_e r;
    if (adr <= SRAM_TOP) begin
      r = REGION_SRAM;
    end else if (adr[ADR_W-1:2] == IO_BASE[ADR_W-1:2]) begin
      r = REGION_IO;
    end else begin
      r = REGION_UNMAPPED;
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// CPU data-memory bus: request/handshake signals between the CPU (master)
// and the memory responder (slave).
interface dm_responder_if;
  import rj32_bus_pkg::*;

  logic             dm_req;
  logic             dm_we;
  logic [ADR_W-1:0] dm_adr;
  logic [DAT_W-1:0] dm_dat_i;
  logic [DAT_W-1:0] dm_dat_o;
  logic             dm_ack;

  modport master (
    output dm_req, dm_we, dm_adr, dm_dat_i,
    input  dm_dat_o, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_adr, dm_dat_i,
    output dm_dat_o, dm_ack
  );

endinterface

// File: rtl/dm_io_regs.sv
// Memory-mapped I/O page: free-running cycle counter with high-half snapshot,
// LED register and sticky bus-error status, plus the combinational read mux.
module dm_io_regs
  import rj32_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  logic             unmapped,
  input  io_req_t          acc,
  output logic [DAT_W-1:0] rdata_c,
  output logic [LED_W-1:0] leds,
  output logic             bus_error
);

  logic [CNT_W-1:0] cnt;
  logic [DAT_W-1:0] snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Side effects land on the edge that accepts the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      leds      <= '0;
      bus_error <= 1'b0;
    end else if (commit) begin
      if (unmapped) begin
        bus_error <= 1'b1;
      end else begin
        case (acc.off)
          IO_CNT_LO: if (!acc.wr) snap <= cnt[CNT_W-1:DAT_W];
          IO_LEDS:   if (acc.wr) leds <= acc.wdat;
          IO_STATUS: if (acc.wr && acc.wdat[0]) bus_error <= 1'b0;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (!unmapped) begin
      case (acc.off)
        IO_CNT_LO: rdata_c = cnt[DAT_W-1:0];
        IO_CNT_HI: rdata_c = snap;
        IO_LEDS:   rdata_c = DAT_W'(leds);
        IO_STATUS: rdata_c = DAT_W'(bus_error);
        default:   rdata_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/dm_responder.sv
// rj32 data-memory bus responder: sequences asynchronous SRAM accesses and the
// I/O page, answering every request with exactly one registered ack pulse.
module dm_responder
  import rj32_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dm_responder_if.slave         bus,
  output logic [SRAM_ADR_W-1:0] sram_adr,
  output logic [DAT_W-1:0]      sram_dat_o,
  input  logic [DAT_W-1:0]      sram_dat_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [LED_W-1:0]      leds,
  output logic                  bus_error
);

  localparam logic [WAIT_W-1:0] WS_LOAD = WAIT_W'(WAIT_STATES);

  dm_state_e        state;
  dm_state_e        state_nxt;
  logic [WAIT_W-1:0] wcnt;
  logic [WAIT_W-1:0] wcnt_nxt;
  logic             txn_we;

  region_e          region_c;
  logic             accept_c;
  logic             op_we_c;
  logic             io_commit_c;
  logic             unmapped_c;
  io_req_t          io_acc_c;
  logic [DAT_W-1:0] io_rdata_c;

  logic             ack_d;
  logic [DAT_W-1:0] dat_d;
  logic             ce_n_d;
  logic             oe_n_d;
  logic             we_n_d;

  assign region_c    = dm_decode(bus.dm_adr);
  assign accept_c    = (state == ST_IDLE) && bus.dm_req;
  assign op_we_c     = accept_c ? bus.dm_we : txn_we;
  assign io_commit_c = accept_c && (region_c != REGION_SRAM);
  assign unmapped_c  = (region_c == REGION_UNMAPPED);
  assign io_acc_c    = '{wr: bus.dm_we, off: bus.dm_adr[1:0], wdat: bus.dm_dat_i[LED_W-1:0]};

  dm_io_regs u_io_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit    (io_commit_c),
    .unmapped  (unmapped_c),
    .acc       (io_acc_c),
    .rdata_c   (io_rdata_c),
    .leds      (leds),
    .bus_error (bus_error)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      txn_we <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (accept_c) txn_we <= bus.dm_we;
    end
  end

  // ACCESS lasts WAIT_STATES+1 cycles: wcnt counts down from WS_LOAD to 0.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      ST_IDLE: begin
        if (bus.dm_req) begin
          if (region_c == REGION_SRAM) begin
            state_nxt = ST_ACCESS;
            wcnt_nxt  = WS_LOAD;
          end else begin
            state_nxt = ST_ACK;
          end
        end
      end
      ST_ACCESS: begin
        if (wcnt == '0) begin
          state_nxt = ST_ACK;
        end else begin
          wcnt_nxt = wcnt - WAIT_W'(1);
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs for the next cycle; the first write cycle is address setup.
  always_comb begin
    ack_d  = 1'b0;
    dat_d  = '0;
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    if (state_nxt == ST_ACCESS) begin
      ce_n_d = 1'b0;
      oe_n_d = op_we_c;
      we_n_d = !op_we_c || (wcnt_nxt == WS_LOAD);
    end
    if (state_nxt == ST_ACK) begin
      ack_d  = 1'b1;
      ce_n_d = !((state == ST_ACCESS) && txn_we);
      if ((state == ST_ACCESS) && !txn_we) begin
        dat_d = sram_dat_i;
      end else if (accept_c && !bus.dm_we) begin
        dat_d = io_rdata_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dm_ack   <= 1'b0;
      bus.dm_dat_o <= '0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
    end else begin
      bus.dm_ack   <= ack_d;
      bus.dm_dat_o <= dat_d;
      sram_ce_n    <= ce_n_d;
      sram_oe_n    <= oe_n_d;
      sram_we_n    <= we_n_d;
    end
  end

  // Address and write data are captured at acceptance and held through the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_adr   <= '0;
      sram_dat_o <= '0;
    end else if (accept_c && (region_c == REGION_SRAM)) begin
      sram_adr <= SRAM_ADR_W'(bus.dm_adr);
      if (bus.dm_we) sram_dat_o <= bus.dm_dat_i;
    end
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Target (responder) end of the rj32 data-memory bus: accepts `req`/`we`/`adr`/`dat` transactions from the CPU and answers each with exactly one `ack` pulse. It sits in `top` between the CPU data port and the external asynchronous SRAM, and also decodes a small memory-mapped I/O page (cycle counter, LED register, bus-error status). All transactions complete; none are dropped.

## Interface
- `WAIT_STATES`, default 1: SRAM access cycles beyond the first (legal range 1..7).
- `clk` in 1: CPU clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dm_req` in 1: CPU request, held high until `dm_ack`.
- `dm_we` in 1: 1 = write, 0 = read; stable while `dm_req` is high.
- `dm_adr` in 16: word address; stable while `dm_req` is high.
- `dm_dat_i` in 16: write data from the CPU; stable while `dm_req` is high.
- `dm_dat_o` out 16: read data to the CPU, valid only while `dm_ack` is high.
- `dm_ack` out 1: one-cycle completion pulse.
- `sram_adr` out 18: SRAM address, `{2'b00, dm_adr}`.
- `sram_dat_o` out 16: SRAM write data.
- `sram_dat_i` in 16: SRAM read data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: SRAM strobes, active low.
- `leds` out 8: LED register contents.
- `bus_error` out 1: sticky unmapped-access flag.

## Operation
- Address decode:
  - 0x0000–0xEFFF: SRAM.
  - 0xFF00: cycle counter low (read-only).
  - 0xFF01: counter high snapshot (read-only).
  - 0xFF02: LED register (read/write, bits 7:0; reads return zero-extended).
  - 0xFF03: status; bit0 = `bus_error`. Writing 1 to bit0 clears it.
  - Everything else is unmapped: reads return 0x0000, writes are discarded, `bus_error` is set. The access is still acked.
- Cycle counter: 32-bit, free-running, +1 every clock, wraps at 0xFFFF_FFFF → 0.
  - A read of 0xFF00 returns bits 15:0 and latches bits 31:16 into the snapshot register in the same cycle.
  - 0xFF01 returns the snapshot, never the live value.
  - Writes to 0xFF00/0xFF01 are ignored and are not errors.
- FSM states:
  - IDLE → ACCESS when `dm_req` is high and the address is SRAM.
  - IDLE → ACK when `dm_req` is high and the address is I/O or unmapped.
  - ACCESS stays for 1+`WAIT_STATES` cycles (3-bit down-counter), then → ACK.
  - ACK → IDLE unconditionally.
- SRAM read:
  - `ce_n` and `oe_n` low for all ACCESS cycles.
  - `sram_dat_i` is registered on the last ACCESS cycle.
  - `dm_dat_o` presents the registered value during ACK.
- SRAM write:
  - `ce_n` low for all ACCESS cycles and ACK.
  - `we_n` low on ACCESS cycles 2..last only; the first cycle is address setup.
  - `we_n` is high in ACK (data hold).
  - `sram_dat_o` = `dm_dat_i`, driven for the whole transaction.
  - `oe_n` stays high.
- I/O side effects (register write, counter snapshot, error set/clear) commit on the IDLE→ACK edge.
- `dm_dat_o` = 0 whenever `dm_ack` is low.

## Timing
- Reset values:
  - `dm_ack` = 0, `dm_dat_o` = 0.
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
  - `leds` = 0, `bus_error` = 0, counter = 0, snapshot = 0, state = IDLE.
- Reset asserted mid-access forces every strobe high and `dm_ack` low immediately (asynchronously). The interrupted transaction is abandoned, not acked.
- Latency, counting `dm_req` first sampled in IDLE at edge 0:
  - I/O or unmapped: `dm_ack` high in cycle 1.
  - SRAM: `dm_ack` high in cycle 2+`WAIT_STATES` (cycle 3 at default).
- `dm_ack` is high for exactly one cycle.
- The responder is back in IDLE the cycle after ack. If `dm_req` is still high there, it is accepted as a new transaction; the CPU must drop `req` or present the next request.
- Minimum spacing is one request per 2 cycles (I/O) or per 3+`WAIT_STATES` cycles (SRAM).
- Software clearing `bus_error` and an unmapped access in the same cycle cannot happen (single port). A status write with bit0 = 0 leaves the flag unchanged.

## Structure
- Shared package `rj32_bus_pkg` holds:
  - FSM state encoding (IDLE/ACCESS/ACK).
  - I/O page constants: `IO_BASE`=0xFF00, offsets 0–3, `SRAM_TOP`=0xEFFF.
  - Default `WAIT_STATES`.
- One sub-module, `dm_io_regs`, holds the counter, snapshot, LED and status registers plus the read mux. The FSM and SRAM strobes stay in `dm_responder`.

## Test plan
- SRAM write then read, `WAIT_STATES`=1: write 0x1234 to 0x0042, then read 0x0042. Required:
  - `sram_adr` = 0x00042.
  - `we_n` low for exactly 1 cycle, not in the first ACCESS cycle.
  - Read ack at cycle 3 with `dm_dat_o` = 0x1234.
- LED register: write 0x00A5 to 0xFF02 → ack at cycle 1, `leds` = 0xA5; read 0xFF02 → 0x00A5.
- Counter snapshot:
  - Release reset, read 0xFF00 at a known cycle → low half matches the elapsed-cycle model.
  - Run 100 further cycles, read 0xFF01 → equals the high half captured at the 0xFF00 read, not the live value.
- Unmapped access:
  - Read 0xF800 → `dm_dat_o` = 0x0000, acked at cycle 1, `bus_error` = 1.
  - Write 0x0001 to 0xFF03 → `bus_error` = 0.
- Back-to-back: hold `dm_req` high across the ack for two SRAM reads → two separate one-cycle acks, 4 cycles apart at default `WAIT_STATES`.
- Reset mid-write: assert `rst_n` low during the `we_n`-low cycle → all strobes high at once, no ack, `leds` = 0; the bus resumes cleanly after release.
